// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select and IF/ID register,
// plus saturating stall/flush counters for performance reporting.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pcwrite_i,
  input  logic             ifid_write_i,
  input  logic             ifid_flush_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_addr_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [31:0]      pc_q;
  logic [31:0]      pc4;
  logic [31:0]      next_pc;
  logic [31:0]      ifid_pc4_q;
  logic [31:0]      ifid_instr_q;
  logic             ifid_valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  assign pc4 = pc_q + 32'd4;

  // Branch (resolved in MEM) is older than the jump in ID, so it wins.
  // Jump region bits come from the jump's own PC+4 held in IF/ID.
  always_comb begin
    next_pc = pc4;
    if (branch_taken_i) begin
      next_pc = {branch_target_i[31:2], 2'b00};
    end else if (jump_i) begin
      next_pc = {ifid_pc4_q[31:28], jump_addr_i, 2'b00};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= 32'h0;
      ifid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (pcwrite_i) begin
        pc_q <= next_pc;
      end

      if (ifid_flush_i) begin
        ifid_pc4_q   <= 32'h0;
        ifid_instr_q <= 32'h0;
        ifid_valid_q <= 1'b0;
      end else if (ifid_write_i) begin
        ifid_pc4_q   <= pc4;
        ifid_instr_q <= instr_i;
        ifid_valid_q <= 1'b1;
      end

      if (!pcwrite_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush_i && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign pc_o         = pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default-width instance and a CNT_W=2 instance
// share all stimulus; the narrow one exercises counter saturation and RESET_PC.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pcwrite;
  logic        ifid_write;
  logic        ifid_flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_addr;
  logic [31:0] instr;

  logic [31:0] pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic [31:0] pc_b;
  logic [31:0] ifid_pc4_b;
  logic [31:0] ifid_instr_b;
  logic        ifid_valid_b;
  logic [1:0]  stall_cnt_b;
  logic [1:0]  flush_cnt_b;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc4_q[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .jump_i(jump), .jump_addr_i(jump_addr),
    .instr_i(instr), .pc_o(pc), .ifid_pc4_o(ifid_pc4), .ifid_instr_o(ifid_instr),
    .ifid_valid_o(ifid_valid), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0000_0100), .CNT_W(2)) dut_narrow (
    .clk_i(clk), .rst_i(rst), .pcwrite_i(pcwrite), .ifid_write_i(ifid_write),
    .ifid_flush_i(ifid_flush), .branch_taken_i(branch_taken),
    .branch_target_i(branch_target), .jump_i(jump), .jump_addr_i(jump_addr),
    .instr_i(instr), .pc_o(pc_b), .ifid_pc4_o(ifid_pc4_b), .ifid_instr_o(ifid_instr_b),
    .ifid_valid_o(ifid_valid_b), .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures = failures + 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pcwrite       = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_addr     = 26'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    instr = 32'hDEAD_BEEF;
    step();
    step();
    checks = checks + 1;
    if (pc !== 32'h0) begin
      $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); failures = failures + 1;
    end
    checks = checks + 1;
    if ({ifid_pc4, ifid_instr, ifid_valid} !== 65'h0) begin
      $display("FAIL reset_ifid actual=%h/%h/%b required=0/0/0", ifid_pc4, ifid_instr, ifid_valid);
      failures = failures + 1;
    end
    checks = checks + 1;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL reset_cnt actual=%0d/%0d required=0/0", stall_cnt, flush_cnt); failures = failures + 1;
    end
    checks = checks + 1;
    if (pc_b !== 32'h100) begin
      $display("FAIL reset_pc_param actual=%h required=%h", pc_b, 32'h100); failures = failures + 1;
    end
  endtask

  task automatic test_seq_fetch();
    rst   = 1'b0;
    instr = 32'h2001_0005;
    step();
    checks = checks + 1;
    if (pc !== 32'h4 || ifid_instr !== 32'h2001_0005 || ifid_pc4 !== 32'h4 || ifid_valid !== 1'b1) begin
      $display("FAIL seq_first actual=pc %h instr %h pc4 %h v %b required=pc 4 instr 20010005 pc4 4 v 1",
               pc, ifid_instr, ifid_pc4, ifid_valid);
      failures = failures + 1;
    end
    step();
    checks = checks + 1;
    if (pc !== 32'h8 || ifid_pc4 !== 32'h8) begin
      $display("FAIL seq_second actual=pc %h pc4 %h required=pc 8 pc4 8", pc, ifid_pc4); failures = failures + 1;
    end
  endtask

  task automatic test_stall();
    pcwrite    = 1'b0;
    ifid_write = 1'b0;
    instr      = 32'h8C22_0000;
    step();
    checks = checks + 1;
    if (pc !== 32'h8 || ifid_instr !== 32'h2001_0005 || ifid_pc4 !== 32'h8 || ifid_valid !== 1'b1) begin
      $display("FAIL stall_hold actual=pc %h instr %h pc4 %h v %b required=pc 8 instr 20010005 pc4 8 v 1",
               pc, ifid_instr, ifid_pc4, ifid_valid);
      failures = failures + 1;
    end
    checks = checks + 1;
    if (stall_cnt !== 16'd1) begin
      $display("FAIL stall_cnt actual=%0d required=1", stall_cnt); failures = failures + 1;
    end
    pcwrite    = 1'b1;
    ifid_write = 1'b1;
    step();
    checks = checks + 1;
    if (pc !== 32'hC || ifid_instr !== 32'h8C22_0000 || ifid_pc4 !== 32'hC) begin
      $display("FAIL stall_resume actual=pc %h instr %h pc4 %h required=pc c instr 8c220000 pc4 c",
               pc, ifid_instr, ifid_pc4);
      failures = failures + 1;
    end
  endtask

  task automatic test_branch();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0043;
    ifid_flush    = 1'b1;
    step();
    idle_inputs();
    checks = checks + 1;
    if (pc !== 32'h40) begin
      $display("FAIL branch_pc actual=%h required=%h", pc, 32'h40); failures = failures + 1;
    end
    checks = checks + 1;
    if (ifid_instr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0) begin
      $display("FAIL branch_bubble actual=%h/%h/%b required=0/0/0 (flush beats write)",
               ifid_instr, ifid_pc4, ifid_valid);
      failures = failures + 1;
    end
    checks = checks + 1;
    if (flush_cnt !== 16'd1) begin
      $display("FAIL branch_flush_cnt actual=%0d required=1", flush_cnt); failures = failures + 1;
    end
  endtask

  task automatic test_jump();
    branch_taken  = 1'b1;
    branch_target = 32'h1000_000C;
    ifid_flush    = 1'b1;
    step();
    idle_inputs();
    instr = 32'h0800_0100;
    step();
    checks = checks + 1;
    if (ifid_pc4 !== 32'h1000_0010 || pc !== 32'h1000_0010) begin
      $display("FAIL jump_setup actual=pc %h pc4 %h required=10000010/10000010", pc, ifid_pc4);
      failures = failures + 1;
    end
    jump       = 1'b1;
    jump_addr  = 26'h000_0100;
    ifid_flush = 1'b1;
    step();
    idle_inputs();
    checks = checks + 1;
    if (pc !== 32'h1000_0400) begin
      $display("FAIL jump_pc actual=%h required=%h", pc, 32'h1000_0400); failures = failures + 1;
    end
    checks = checks + 1;
    if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || flush_cnt !== 16'd3) begin
      $display("FAIL jump_bubble actual=v %b instr %h flushes %0d required=v 0 instr 0 flushes 3",
               ifid_valid, ifid_instr, flush_cnt);
      failures = failures + 1;
    end
  endtask

  task automatic test_wrap();
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFE;
    ifid_flush    = 1'b1;
    step();
    idle_inputs();
    instr = 32'h0000_0020;
    checks = checks + 1;
    if (pc !== 32'hFFFF_FFFC) begin
      $display("FAIL wrap_align actual=%h required=fffffffc", pc); failures = failures + 1;
    end
    step();
    checks = checks + 1;
    if (pc !== 32'h0 || ifid_pc4 !== 32'h0 || ifid_valid !== 1'b1) begin
      $display("FAIL wrap_pc4 actual=pc %h pc4 %h v %b required=0/0/1", pc, ifid_pc4, ifid_valid);
      failures = failures + 1;
    end
  endtask

  task automatic test_branch_and_jump();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0080;
    jump          = 1'b1;
    jump_addr     = 26'h000_0100;
    ifid_flush    = 1'b1;
    step();
    idle_inputs();
    checks = checks + 1;
    if (pc !== 32'h80) begin
      $display("FAIL branch_over_jump actual=%h required=80", pc); failures = failures + 1;
    end
  endtask

  task automatic test_redirect_ignored();
    pcwrite       = 1'b0;
    ifid_write    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    step();
    idle_inputs();
    checks = checks + 1;
    if (pc !== 32'h80 || stall_cnt !== 16'd2) begin
      $display("FAIL redirect_ignored actual=pc %h stalls %0d required=pc 80 stalls 2", pc, stall_cnt);
      failures = failures + 1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    exp_pc = 32'h80;
    for (int i = 0; i < 4; i++) begin
      instr = 32'hA000_0000 + 32'(i * 17);
      exp_q.push_back(instr);
      exp_pc4_q.push_back(exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      step();
      e_instr = exp_q.pop_front();
      e_pc4   = exp_pc4_q.pop_front();
      checks = checks + 1;
      if (ifid_instr !== e_instr || ifid_pc4 !== e_pc4 || pc !== exp_pc) begin
        $display("FAIL b2b_%0d actual=instr %h pc4 %h pc %h required=instr %h pc4 %h pc %h",
                 i, ifid_instr, ifid_pc4, pc, e_instr, e_pc4, exp_pc);
        failures = failures + 1;
      end
    end
  endtask

  task automatic test_saturation_reset();
    logic [1:0] exp_sat[5];
    exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1;
    step();
    rst        = 1'b0;
    pcwrite    = 1'b0;
    ifid_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks = checks + 1;
      if (stall_cnt_b !== exp_sat[i]) begin
        $display("FAIL sat_%0d actual=%0d required=%0d", i, stall_cnt_b, exp_sat[i]); failures = failures + 1;
      end
    end
    checks = checks + 1;
    if (stall_cnt !== 16'd5 || pc_b !== 32'h100) begin
      $display("FAIL sat_wide actual=stalls %0d pc %h required=5/100", stall_cnt, pc_b); failures = failures + 1;
    end
    ifid_flush = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    checks = checks + 1;
    if (stall_cnt_b !== 2'd0 || flush_cnt_b !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      $display("FAIL midreset_cnt actual=%0d/%0d/%0d/%0d required=0/0/0/0",
               stall_cnt_b, flush_cnt_b, stall_cnt, flush_cnt);
      failures = failures + 1;
    end
    checks = checks + 1;
    if (pc_b !== 32'h100 || pc !== 32'h0 || ifid_valid !== 1'b0) begin
      $display("FAIL midreset_pc actual=%h/%h v %b required=100/0 v 0", pc_b, pc, ifid_valid);
      failures = failures + 1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_seq_fetch();
    test_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_branch_and_jump();
    test_redirect_ignored();
    test_back_to_back();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
